// File: rtl/ex_agu_pipe.sv
// ----------------------------------------------------------------------------
// ex_agu_pipe
//
// Two-stage pipelined address generation unit for the execute path.
// Computes Rm + (extend(Ri) << scale) at AW bits, predicated on SR.T, and
// flags accesses that are not naturally aligned to their size.
//
// Stage 1 extends and scales the index and evaluates the predicate.
// Stage 2 performs the add and the alignment check.
//
// Parameters:
//   AW          address / base register width (32..64)
//   XW          index register width (8..AW)
//
// Ports:
//   clock       core clock, all state updates on the rising edge
//   reset       synchronous active-high reset, overrides exHold
//   exHold      pipeline stall, both stages hold while high
//   iValid      operands valid this cycle
//   regValRm    base register value (AW bits)
//   regValRi    index register value (XW bits)
//   idUIxt      control: [7:6] CC, [5:4] size, [2] ZExt, [1:0] scale;
//               bits [8] and [3] are reserved and ignored
//   srT         SR.T bit, sampled in stage 1
//   oValid      result valid
//   regOutAddr  effective address (AW bits)
//   oMisalign   address not aligned to access size (meaningful with oValid)
//   oSize       access size forwarded from idUIxt[5:4]
//
// Configuration macro:
//   EX_AGU_MISALIGN_EN  when defined, the misalign flag and its stage-2
//                       register are built; otherwise oMisalign is tied to 0.
// ----------------------------------------------------------------------------
module ex_agu_pipe #(
    parameter int AW = 48,
    parameter int XW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          exHold,
    input  logic          iValid,
    input  logic [AW-1:0] regValRm,
    input  logic [XW-1:0] regValRi,
    input  logic [8:0]    idUIxt,
    input  logic          srT,
    output logic          oValid,
    output logic [AW-1:0] regOutAddr,
    output logic          oMisalign,
    output logic [1:0]    oSize
);

    localparam logic [1:0] CC_AL = 2'b00;
    localparam logic [1:0] CC_NV = 2'b01;
    localparam logic [1:0] CC_CT = 2'b10;
    localparam logic [1:0] CC_CF = 2'b11;

    logic [1:0]    w_cc;
    logic [1:0]    w_size;
    logic          w_zext;
    logic [1:0]    w_scale;
    logic          w_pred;
    logic [AW-1:0] w_extIdx;
    logic [AW-1:0] w_scaledIdx;
    logic [AW-1:0] w_addr;
    logic          w_unusedCtl;

    logic          r_s1Valid;
    logic [AW-1:0] r_s1Rm;
    logic [AW-1:0] r_s1Idx;
    logic [1:0]    r_s1Size;

    logic          r_oValid;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;

    assign w_cc        = idUIxt[7:6];
    assign w_size      = idUIxt[5:4];
    assign w_zext      = idUIxt[2];
    assign w_scale     = idUIxt[1:0];
    assign w_unusedCtl = idUIxt[8] ^ idUIxt[3];

    // Predicate from the condition code: always, never, or on SR.T true/false.
    always_comb begin
        w_pred = 1'b0;
        case (w_cc)
            CC_AL:   w_pred = 1'b1;
            CC_NV:   w_pred = 1'b0;
            CC_CT:   w_pred = srT;
            CC_CF:   w_pred = ~srT;
            default: w_pred = 1'b0;
        endcase
    end

    // Widen the index to the address width. A full-width index needs no
    // fill, and a zero-length replication is not legal, hence the split.
    generate
        if (XW == AW) begin : g_noExt
            assign w_extIdx = regValRi;
        end else begin : g_ext
            logic w_fill;
            assign w_fill   = ~w_zext & regValRi[XW-1];
            assign w_extIdx = {{(AW-XW){w_fill}}, regValRi};
        end
    endgenerate

    // Bits shifted past AW are simply lost, matching modulo-2^AW addressing.
    assign w_scaledIdx = w_extIdx << w_scale;

    // Stage 1 register. Squashed ops still move forward with valid low; their
    // data fields are don't-care downstream so they update unconditionally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Rm    <= '0;
            r_s1Idx   <= '0;
            r_s1Size  <= 2'b00;
        end else if (!exHold) begin
            r_s1Valid <= iValid & w_pred;
            r_s1Rm    <= regValRm;
            r_s1Idx   <= w_scaledIdx;
            r_s1Size  <= w_size;
        end
    end

    // Carry out of the add is discarded; wrapping through zero is not a fault.
    assign w_addr = r_s1Rm + r_s1Idx;

    // Stage 2 register for address, valid and forwarded size.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_oValid <= 1'b0;
            r_addr   <= '0;
            r_size   <= 2'b00;
        end else if (!exHold) begin
            r_oValid <= r_s1Valid;
            r_addr   <= w_addr;
            r_size   <= r_s1Size;
        end
    end

`ifdef EX_AGU_MISALIGN_EN
    logic w_misalign;
    logic r_misalign;

    // Natural alignment: byte never faults, larger sizes need their low
    // address bits clear.
    always_comb begin
        w_misalign = 1'b0;
        case (r_s1Size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_addr[0];
            2'd2:    w_misalign = |w_addr[1:0];
            2'd3:    w_misalign = |w_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Misalign flag register, held and cleared together with the address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (!exHold) begin
            r_misalign <= w_misalign;
        end
    end

    assign oMisalign = r_misalign;
`else
    assign oMisalign = 1'b0;
`endif

    assign oValid     = r_oValid;
    assign regOutAddr = r_addr;
    assign oSize      = r_size;

endmodule

// File: tb/tb_ex_agu_pipe.sv
// ----------------------------------------------------------------------------
// tb_ex_agu_pipe
//
// Self-checking bench for ex_agu_pipe at AW=48, XW=32. A directed vector
// table covers the arithmetic corner cases, hand-written sequences cover
// predication back-to-back, hold and reset, and a randomized phase compares
// every cycle against an arithmetic reference model with a delay queue.
// ----------------------------------------------------------------------------
module tb_ex_agu_pipe;

    localparam int AW = 48;
    localparam int XW = 32;

    logic          clock;
    logic          reset;
    logic          exHold;
    logic          iValid;
    logic [AW-1:0] regValRm;
    logic [XW-1:0] regValRi;
    logic [8:0]    idUIxt;
    logic          srT;
    logic          oValid;
    logic [AW-1:0] regOutAddr;
    logic          oMisalign;
    logic [1:0]    oSize;

    int checks;
    int errors;

    typedef struct {
        logic          v;
        logic          chk;
        logic [AW-1:0] a;
        logic          m;
        logic [1:0]    s;
    } outRec_t;

    typedef struct {
        logic [AW-1:0] rm;
        logic [XW-1:0] ri;
        logic [1:0]    cc;
        logic [1:0]    size;
        logic          zx;
        logic [1:0]    scale;
        logic          t;
        logic          expV;
        logic [AW-1:0] expA;
        logic          expM;
    } vec_t;

    ex_agu_pipe #(.AW(AW), .XW(XW)) dut (
        .clock      (clock),
        .reset      (reset),
        .exHold     (exHold),
        .iValid     (iValid),
        .regValRm   (regValRm),
        .regValRi   (regValRi),
        .idUIxt     (idUIxt),
        .srT        (srT),
        .oValid     (oValid),
        .regOutAddr (regOutAddr),
        .oMisalign  (oMisalign),
        .oSize      (oSize)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle a little past the edge before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Effective address from the rules: extend the index as a signed or
    // unsigned integer, multiply by 2^scale, add and reduce modulo 2^AW.
    function automatic logic [AW-1:0] refAddr(input logic [AW-1:0] rm, input logic [XW-1:0] ri,
                                              input logic zx, input logic [1:0] sc);
        longint     e;
        logic [63:0] t;
        if (zx) e = longint'(ri);
        else    e = longint'($signed(ri));
        t = 64'(longint'(rm) + e * (longint'(1) << sc));
        return t[AW-1:0];
    endfunction

    // Expected misalign: the address is not a multiple of the access size.
    function automatic logic refMis(input logic [AW-1:0] a, input logic [1:0] s);
`ifdef EX_AGU_MISALIGN_EN
        logic [63:0] full;
        full = 64'(a);
        return (full % (64'd1 << s)) != 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic refPred(input logic [1:0] cc, input logic t);
        if (cc == 2'b00) return 1'b1;
        if (cc == 2'b01) return 1'b0;
        if (cc == 2'b10) return t;
        return ~t;
    endfunction

    // Drive one set of operands; reserved control bits get random values.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] rm, input logic [XW-1:0] ri,
                                 input logic [1:0] cc, input logic [1:0] size, input logic zx,
                                 input logic [1:0] scale, input logic t);
        iValid   = v;
        regValRm = rm;
        regValRi = ri;
        idUIxt   = {1'($urandom), cc, size, 1'($urandom), zx, scale};
        srT      = t;
    endtask

    // Compare the DUT outputs with an expected record; data fields only when
    // they are defined (valid result or freshly reset).
    task automatic checkOutput(input string name, input outRec_t e);
        checks++;
        if (oValid !== e.v) begin
            errors++;
            $display("[TB] FAIL %s oValid got %0b want %0b", name, oValid, e.v);
        end
        if (e.chk) begin
            checks++;
            if (regOutAddr !== e.a) begin
                errors++;
                $display("[TB] FAIL %s addr got 0x%012h want 0x%012h", name, regOutAddr, e.a);
            end
            checks++;
            if (oMisalign !== e.m) begin
                errors++;
                $display("[TB] FAIL %s misalign got %0b want %0b", name, oMisalign, e.m);
            end
            checks++;
            if (oSize !== e.s) begin
                errors++;
                $display("[TB] FAIL %s size got %0d want %0d", name, oSize, e.s);
            end
        end
    endtask

    function automatic outRec_t mkRec(input logic v, input logic [AW-1:0] a, input logic [1:0] s);
        outRec_t r;
        r.v   = v;
        r.chk = v;
        r.a   = a;
        r.m   = refMis(a, s);
        r.s   = s;
        return r;
    endfunction

    function automatic outRec_t resetRec();
        outRec_t r;
        r.v   = 1'b0;
        r.chk = 1'b1;
        r.a   = '0;
        r.m   = 1'b0;
        r.s   = 2'b00;
        return r;
    endfunction

    function automatic outRec_t bubbleRec();
        outRec_t r;
        r     = resetRec();
        r.chk = 1'b0;
        return r;
    endfunction

    vec_t    vecs[10];
    outRec_t q[$];
    outRec_t modelOut;
    outRec_t e;
    outRec_t recA, recB, recC, recD;

    // Main test sequence: reset, directed table, hand-written corner
    // sequences, then randomized comparison against the reference model.
    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        exHold   = 1'b0;
        applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

        // Directed vectors: rm, ri, cc, size, zx, scale, srT, expV, expA, expM(with macro).
        vecs[0] = '{48'h0000_0000_1000, 32'hFFFF_FFFF, 2'b00, 2'd2, 1'b0, 2'd2, 1'b0, 1'b1, 48'h0000_0000_0FFC, 1'b0};
        vecs[1] = '{48'h0000_0000_1000, 32'hFFFF_FFFF, 2'b00, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1, 48'h0004_0000_0FFC, 1'b0};
        vecs[2] = '{48'h0000_0000_2001, 32'h0000_0002, 2'b00, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 48'h0000_0000_2005, 1'b1};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 32'h0000_0001, 2'b00, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 48'h0000_0000_0000, 1'b0};
        vecs[4] = '{48'h0000_0000_0100, 32'h0000_0004, 2'b00, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1, 48'h0000_0000_0104, 1'b1};
        vecs[5] = '{48'h0000_0000_0100, 32'h0000_0001, 2'b00, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 48'h0000_0000_0108, 1'b0};
        vecs[6] = '{48'h0000_0001_0000, 32'hFFFF_FFFE, 2'b00, 2'd3, 1'b0, 2'd3, 1'b0, 1'b1, 48'h0000_0000_FFF0, 1'b0};
        vecs[7] = '{48'h0000_0000_0000, 32'h8000_0000, 2'b00, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1, 48'hFFFF_8000_0000, 1'b0};
        vecs[8] = '{48'h0000_0000_1002, 32'h0000_0000, 2'b10, 2'd2, 1'b0, 2'd0, 1'b1, 1'b1, 48'h0000_0000_1002, 1'b1};
        vecs[9] = '{48'h0000_0000_1000, 32'h0000_0010, 2'b11, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 48'h0000_0000_0000, 1'b0};

        tick();
        tick();
        checkOutput("reset", resetRec());
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].rm, vecs[i].ri, vecs[i].cc, vecs[i].size, vecs[i].zx, vecs[i].scale, vecs[i].t);
            tick();
            applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
            checkOutput($sformatf("vec%0d_lat1", i), bubbleRec());
            tick();
            e = mkRec(vecs[i].expV, vecs[i].expA, vecs[i].size);
`ifdef EX_AGU_MISALIGN_EN
            e.m = vecs[i].expM;
`else
            e.m = 1'b0;
`endif
            checkOutput($sformatf("vec%0d", i), e);
        end

        // Predication back to back: CT/T=0, CF/T=0, NV, AL.
        applyStimulus(1'b1, 48'h10, 32'h1, 2'b10, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 48'h20, 32'h1, 2'b11, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("pred_ct", bubbleRec());
        applyStimulus(1'b1, 48'h30, 32'h1, 2'b01, 2'd0, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("pred_cf", mkRec(1'b1, 48'h21, 2'd0));
        applyStimulus(1'b1, 48'h40, 32'h1, 2'b00, 2'd0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("pred_nv", bubbleRec());
        applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        tick();
        checkOutput("pred_al", mkRec(1'b1, 48'h41, 2'd0));
        tick();

        // Hold for 3 cycles mid-stream of four ops A..D.
        recA = mkRec(1'b1, 48'h1100, 2'd2);
        recB = mkRec(1'b1, 48'h2202, 2'd1);
        recC = mkRec(1'b1, 48'h3303, 2'd0);
        recD = mkRec(1'b1, 48'h4400, 2'd3);
        applyStimulus(1'b1, 48'h1000, 32'h40, 2'b00, 2'd2, 1'b0, 2'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 48'h2200, 32'h1, 2'b00, 2'd1, 1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("hold_a", recA);
        applyStimulus(1'b1, 48'h3300, 32'h3, 2'b00, 2'd0, 1'b0, 2'd0, 1'b0);
        exHold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("hold_frozen%0d", k), recA);
        end
        exHold = 1'b0;
        tick();
        checkOutput("hold_b", recB);
        applyStimulus(1'b1, 48'h4000, 32'h80, 2'b00, 2'd3, 1'b0, 2'd3, 1'b0);
        tick();
        checkOutput("hold_c", recC);
        applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        tick();
        checkOutput("hold_d", recD);
        tick();
        checkOutput("hold_nodup", bubbleRec());

        // Reset with two ops in flight, with hold also asserted.
        applyStimulus(1'b1, 48'h5000, 32'h4, 2'b00, 2'd2, 1'b0, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 48'h6000, 32'h4, 2'b00, 2'd2, 1'b0, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        reset  = 1'b1;
        exHold = 1'b1;
        tick();
        checkOutput("rst_flush", resetRec());
        reset  = 1'b0;
        exHold = 1'b0;
        tick();
        checkOutput("rst_discard", resetRec());
        applyStimulus(1'b1, 48'hFFFF_FFFF_FFFF, 32'h1, 2'b00, 2'd0, 1'b1, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_lat1", resetRec());
        tick();
        checkOutput("rst_wrap", mkRec(1'b1, 48'h0, 2'd0));

        // Randomized phase against the reference model with a one-deep queue
        // standing for the op in flight between issue and result.
        reset = 1'b1;
        tick();
        q.delete();
        q.push_back(bubbleRec());
        modelOut = resetRec();
        checkOutput("rand_reset", modelOut);
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [63:0]   rnd;
            logic [AW-1:0] rm;
            logic [XW-1:0] ri;
            logic [1:0]    cc, sz, sc;
            logic          zx, t, v;
            outRec_t       nr;
            rnd = {$urandom, $urandom};
            rm  = ($urandom_range(0, 9) == 0) ? '1 : rnd[AW-1:0];
            ri  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cc  = 2'($urandom);
            sz  = 2'($urandom);
            sc  = 2'($urandom);
            zx  = 1'($urandom);
            t   = 1'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            applyStimulus(v, rm, ri, cc, sz, zx, sc, t);
            exHold = ($urandom_range(0, 4) == 0);
            reset  = ($urandom_range(0, 49) == 0);
            nr = mkRec(v & refPred(cc, t), refAddr(rm, ri, zx, sc), sz);
            tick();
            if (reset) begin
                q.delete();
                q.push_back(bubbleRec());
                modelOut = resetRec();
            end else if (!exHold) begin
                modelOut = q.pop_front();
                q.push_back(nr);
            end
            checkOutput($sformatf("rand%0d", c), modelOut);
        end
        reset  = 1'b0;
        exHold = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_agu_pipe.md
# ex_agu_pipe

Two-stage pipelined, parametrised address generation unit for the execute path. It computes Rm + (extend(Ri) << scale) at a configurable address width, with sign- or zero-extension of the index and predication on the SR.T condition. It flags misaligned accesses and supports a pipeline hold. It sits between register-file operand fetch and the L1 data cache request stage, replacing the single-cycle combinational scaled-add AGU.

## Interface
Parameters:
- AW, 48: address width (output and Rm width); legal 32..64.
- XW, 32: index (Ri) width; legal 8..AW.

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- exHold  in  1  pipeline stall; when high, all stage registers hold.
- iValid  in  1  operands valid this cycle.
- regValRm  in  AW  base register.
- regValRi  in  XW  index register.
- idUIxt  in  9  control: [7:6] CC (00=AL, 01=NV, 10=CT, 11=CF), [5:4] access size (B/W/L/Q), [2] ZExt (0=SX, 1=ZX), [1:0] scale (x1/x2/x4/x8); [8] and [3] reserved, ignored.
- srT  in  1  SR.T bit, sampled in stage 1.
- oValid  out  1  result valid.
- regOutAddr  out  AW  effective address.
- oMisalign  out  1  address not aligned to access size (valid only with oValid).
- oSize  out  2  access size forwarded from idUIxt[5:4].

## Operation
Stage 1 (captured when !exHold):
- Extend Ri from XW to AW bits. Zero-fill if ZExt=1, else replicate Ri[XW-1].
- Shift left by scale (0..3). Bits above AW are discarded.
- Register the scaled index, Rm, size and s1Valid.
- s1Valid = iValid & pred, where pred: AL=1, NV=0, CT=srT, CF=!srT.

Stage 2 (captured when !exHold):
- addr = Rm + scaledIdx, modulo 2^AW (carry out discarded, no trap).
- Misalignment by size: B never; W addr[0]; L |addr[1:0]; Q |addr[2:0].
- Register addr, misalign, size and oValid = s1Valid.

Other rules:
- Squashed ops (predicate false) still advance through the pipeline with valid=0. Their data registers update, but the values are don't-care.
- Bubbles (iValid=0) propagate as valid=0.

## Timing
- Latency: 2 cycles from iValid sample to oValid, absent hold. Throughput: 1 op per cycle.
- exHold=1: both stages freeze, outputs keep their prior values (including oValid=1 if held), and new inputs are ignored. Release resumes with no loss or duplication.
- reset=1: s1Valid, oValid, regOutAddr, oMisalign and oSize all clear to 0 on the next edge. Reset overrides exHold.
  - In-flight ops are discarded.
  - The first valid output after reset deassertion is 2 cycles after the first sampled iValid.
- Simultaneous iValid and exHold: the op is not captured. The upstream stage must re-present it, because the shared hold stalls upstream too.
- Address wrap: Rm=all-ones plus index 1 gives 0, with no flag.

## Configuration
- EX_AGU_MISALIGN_EN defined: oMisalign computed as above, and the stage-2 misalign register is present.
- Not defined: oMisalign tied to 0 and the misalign register is removed. Address, valid and size behaviour is unchanged.

## Test plan
- AW=48, XW=32: Rm=0x0000_1000, Ri=0xFFFF_FFFF, ZExt=0, scale=x4, AL, size=L, iValid pulse → 2 cycles later oValid=1, regOutAddr=0x0000_0FFC, oMisalign=0.
- Same, ZExt=1 → regOutAddr=0x0004_0000_0FFC, oMisalign=0.
- Rm=0x2001, Ri=0x2, scale=x2, size=W → addr=0x2005, oMisalign=1 with macro, 0 without.
- Predication, ops back to back: CT with srT=0 → oValid=0; CF with srT=0 → oValid=1; NV → oValid=0; AL → oValid=1.
- Stream of 4 ops, exHold high for 3 cycles mid-stream → outputs frozen during hold; all 4 results appear in order, none duplicated.
- reset asserted while 2 ops are in flight → next cycle oValid=0 and regOutAddr=0; after release, the next op appears 2 cycles after issue. Wrap case: Rm=0xFFFF_FFFF_FFFF, Ri=1, x1 → regOutAddr=0.
